avalon_multi_timer: RTL and testbench
=====================================

# avalon_multi_timer

Parametrised multi-channel Avalon-MM interval timer for the Nios II system, the next generation of the single-channel system timer. It provides NUM_CH independent down-counters of width CNT_W behind one 16-bit slave port, each with its own period, snapshot, continuous/one-shot mode, interrupt enable and a new per-channel prescaler. Per-channel interrupt lines and a combined line feed the CPU interrupt controller. A global pending register lets the ISR identify the source in one read.

## Interface
- NUM_CH, 2, number of channels (1..4)
- CNT_W, 32, counter/period width (17..32); period and snapshot are split into low word [15:0] and high word [CNT_W-1:16]
- DEFAULT_PERIOD, 24999999, reset value of every period register and counter (1 s at 25 MHz)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  $clog2(NUM_CH)+3  {channel, reg[2:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n
- writedata  in  16  write data
- readdata  out  16  registered read data, reset 0
- irq  out  NUM_CH  per-channel interrupt, reset 0
- irq_any  out  1  OR of irq, reset 0

## Operation
- Per-channel register map (reg offset):
  - 0 STATUS: bit0 TO (timeout sticky), bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
    - Bits 0..3 are stored; reset 0.
    - START and STOP also act as one-cycle strobes.
  - 2 PERIODL and 3 PERIODH: writable; upper unused bits of PERIODH read 0.
  - 4 SNAPL and 5 SNAPH: a write to either captures the whole counter; reads return the captured value.
  - 6 PRESCALE: 16-bit; reset 0.
  - 7 PENDING: read-only, bit n = channel n TO; identical in every channel slot.
  - Channel index >= NUM_CH: reads return 0; writes are ignored.
- Tick: a per-channel 16-bit prescale counter pc runs only while RUN=1.
  - tick = RUN && pc==0; on tick, pc reloads to PRESCALE, otherwise pc decrements.
  - PRESCALE=0 gives a tick every cycle.
- Counter on tick:
  - If cnt==0: cnt reloads to period, and RUN clears when CONT=0.
  - Otherwise cnt decrements.
- Timeout event = cnt==0 on this cycle and cnt!=0 on the previous cycle; it sets TO.
- Period write (either half) sets force_reload for one cycle. On the next edge:
  - cnt is loaded with the new period and pc is loaded with PRESCALE;
  - RUN clears.
- START sets RUN and reloads pc to PRESCALE; it does not reload cnt. STOP clears RUN.
- irq[n] = TO[n] && ITO[n].
- Priorities:
  - START with STOP in the same write: START wins.
  - START with force_reload: START wins.
  - STATUS write in the same cycle as a timeout event: the clear wins.
  - Snapshot in the same cycle as a counter update: captures the pre-edge value.
- Arithmetic is unsigned, and cnt never wraps below 0. A period of 0 gives a timeout that latches once and stays at zero without retriggering.

## Timing
- Writes take effect at the clock edge where the write is sampled; the register value is visible one cycle later.
- Reads have 1 cycle latency: readdata is registered from the address presented in the previous cycle. There is no waitrequest.
- RUN goes high the cycle after a START write. The first decrement happens the cycle after that if PRESCALE=0, otherwise PRESCALE+1 cycles later.
- TO sets on the edge following the cycle where cnt first reads 0; irq follows combinationally from TO.
- Timeout spacing in continuous mode is (period+1)·(PRESCALE+1) cycles.
- Reset, asynchronous at any point:
  - cnt = DEFAULT_PERIOD and period = DEFAULT_PERIOD;
  - pc, PRESCALE, CONTROL, TO, RUN, snapshot and readdata = 0.

## Structure
- Package timer_pkg holds:
  - register offset localparams (REG_STATUS..REG_PENDING);
  - CONTROL bit indices (CTL_ITO, CTL_CONT, CTL_START, CTL_STOP);
  - STATUS bit indices.
- Sub-module timer_channel holds one channel: period, prescaler, counter, snapshot and STATUS/CONTROL logic.
  - It takes decoded write strobes and writedata.
  - It outputs its read words, TO and irq.
- The top level instantiates timer_channel NUM_CH times in a generate loop and owns address decode, the read mux, the readdata register and irq_any.

## Test plan
- Reset then read ch0 PERIODL/PERIODH -> 16'h783F and 16'h017D; STATUS reads 0; irq=0.
- ch1: write PERIODL=4, PERIODH=0, CONTROL=4'b0111 -> TO sets 5 cycles after the first decrement and every 5 cycles thereafter; irq[1]=1 and irq_any=1; PENDING reads 2'b10.
- ch0: period 3, PRESCALE=2, CONT=0, START -> counter decrements every 3 cycles, TO sets once, then RUN reads 0.
- Running ch0 with period 10: write PERIODL=7 -> RUN clears the cycle after next and cnt=7. Write CONTROL=4'b1100 -> RUN=1 (START wins).
- Write STATUS in the same cycle as a timeout event -> TO stays 0. A later timeout sets TO; a write of 0 to STATUS clears it and drops irq the next cycle.
- Snapshot: ch0 running, write SNAPL at cnt=0x0001_2345 -> SNAPL/SNAPH read 16'h2345 and 16'h0001. Assert reset_n mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Imported by the channel and by the top-level Avalon slave.
package timer_pkg;

    localparam int NUM_REGS = 8;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIODL  = 3'd2;
    localparam logic [2:0] REG_PERIODH  = 3'd3;
    localparam logic [2:0] REG_SNAPL    = 3'd4;
    localparam logic [2:0] REG_SNAPH    = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [2:0] REG_PENDING  = 3'd7;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period, prescaler, down-counter, snapshot, STATUS/CONTROL.
// Driven by one-hot register write strobes decoded in the top level.
module timer_channel
    import timer_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 24999999
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [NUM_REGS-1:0] wr_i,
    input  logic [15:0]         wdata_i,
    output logic [15:0]         status_o,
    output logic [15:0]         control_o,
    output logic [15:0]         period_lo_o,
    output logic [15:0]         period_hi_o,
    output logic [15:0]         snap_lo_o,
    output logic [15:0]         snap_hi_o,
    output logic [15:0]         prescale_o,
    output logic                to_o,
    output logic                irq_o
);

    logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
    logic [15:0]      pc_q, pc_d, prescale_q, prescale_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             to_q, to_d, run_q, run_d, reload_q, reload_d, prev_nz_q;
    logic             tick, timeout;
    logic [31:0]      period_ext, snap_ext;

    assign tick    = run_q && (pc_q == '0);
    // A timeout is the first cycle the counter sits at zero, so period 0 fires once.
    assign timeout = (cnt_q == '0) && prev_nz_q;

    always_comb begin
        period_d   = period_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        pc_d       = pc_q;
        prescale_d = prescale_q;
        ctl_d      = ctl_q;
        to_d       = to_q;
        run_d      = run_q;
        reload_d   = 1'b0;

        if (run_q) pc_d = tick ? prescale_q : pc_q - 16'd1;
        if (tick) begin
            if (cnt_q == '0) begin
                cnt_d = period_q;
                if (!ctl_q[CTL_CONT]) run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (timeout) to_d = 1'b1;

        if (reload_q) begin
            cnt_d = period_q;
            pc_d  = prescale_q;
            run_d = 1'b0;
        end

        // Later assignments take priority: status clear over timeout, START over STOP/reload.
        if (wr_i[REG_STATUS]) to_d = 1'b0;
        if (wr_i[REG_CONTROL]) begin
            ctl_d = wdata_i[3:0];
            if (wdata_i[CTL_STOP]) run_d = 1'b0;
            if (wdata_i[CTL_START]) begin
                run_d = 1'b1;
                pc_d  = prescale_q;
            end
        end
        if (wr_i[REG_PERIODL]) begin
            period_d[15:0] = wdata_i;
            reload_d       = 1'b1;
        end
        if (wr_i[REG_PERIODH]) begin
            period_d[CNT_W-1:16] = wdata_i[CNT_W-17:0];
            reload_d             = 1'b1;
        end
        if (wr_i[REG_SNAPL] || wr_i[REG_SNAPH]) snap_d = cnt_q;
        if (wr_i[REG_PRESCALE]) prescale_d = wdata_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            period_q   <= CNT_W'(DEFAULT_PERIOD);
            cnt_q      <= CNT_W'(DEFAULT_PERIOD);
            snap_q     <= '0;
            pc_q       <= '0;
            prescale_q <= '0;
            ctl_q      <= '0;
            to_q       <= 1'b0;
            run_q      <= 1'b0;
            reload_q   <= 1'b0;
            prev_nz_q  <= 1'b0;
        end else begin
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            pc_q       <= pc_d;
            prescale_q <= prescale_d;
            ctl_q      <= ctl_d;
            to_q       <= to_d;
            run_q      <= run_d;
            reload_q   <= reload_d;
            prev_nz_q  <= (cnt_q != '0);
        end
    end

    assign period_ext  = 32'(period_q);
    assign snap_ext    = 32'(snap_q);
    assign status_o    = {14'd0, run_q, to_q};
    assign control_o   = {12'd0, ctl_q};
    assign period_lo_o = period_ext[15:0];
    assign period_hi_o = period_ext[31:16];
    assign snap_lo_o   = snap_ext[15:0];
    assign snap_hi_o   = snap_ext[31:16];
    assign prescale_o  = prescale_q;
    assign to_o        = to_q;
    assign irq_o       = to_q && ctl_q[CTL_ITO];

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: address decode, registered read mux
// and interrupt combining around NUM_CH timer_channel instances.
module avalon_multi_timer
    import timer_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 24999999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(NUM_CH)+2:0]    address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [15:0]                  writedata,
    output logic [15:0]                  readdata,
    output logic [NUM_CH-1:0]            irq,
    output logic                         irq_any
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                        wr_en;
    logic [2:0]                  reg_sel;
    logic [CH_W-1:0]             ch_idx;
    logic [NUM_CH-1:0][15:0]     status_w, control_w, period_lo_w, period_hi_w;
    logic [NUM_CH-1:0][15:0]     snap_lo_w, snap_hi_w, prescale_w;
    logic [NUM_CH-1:0]           to_w, irq_w;
    logic [15:0]                 readdata_q, readdata_d;

    assign wr_en   = chipselect && !write_n;
    assign reg_sel = address[2:0];

    generate
        if (NUM_CH > 1) begin : g_sel
            assign ch_idx = address[$clog2(NUM_CH)+2:3];
        end else begin : g_sel_one
            assign ch_idx = '0;
        end
    endgenerate

    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            logic [NUM_REGS-1:0] wr_n;
            assign wr_n = (wr_en && ch_idx == CH_W'(n)) ? (8'd1 << reg_sel) : '0;

            timer_channel #(
                .CNT_W          (CNT_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_ch (
                .clk_i       (clk),
                .reset_ni    (reset_n),
                .wr_i        (wr_n),
                .wdata_i     (writedata),
                .status_o    (status_w[n]),
                .control_o   (control_w[n]),
                .period_lo_o (period_lo_w[n]),
                .period_hi_o (period_hi_w[n]),
                .snap_lo_o   (snap_lo_w[n]),
                .snap_hi_o   (snap_hi_w[n]),
                .prescale_o  (prescale_w[n]),
                .to_o        (to_w[n]),
                .irq_o       (irq_w[n])
            );
        end
    endgenerate

    // Slots for channels that do not exist read as zero.
    always_comb begin
        readdata_d = '0;
        if (32'(ch_idx) < NUM_CH) begin
            case (reg_sel)
                REG_STATUS:   readdata_d = status_w[ch_idx];
                REG_CONTROL:  readdata_d = control_w[ch_idx];
                REG_PERIODL:  readdata_d = period_lo_w[ch_idx];
                REG_PERIODH:  readdata_d = period_hi_w[ch_idx];
                REG_SNAPL:    readdata_d = snap_lo_w[ch_idx];
                REG_SNAPH:    readdata_d = snap_hi_w[ch_idx];
                REG_PRESCALE: readdata_d = prescale_w[ch_idx];
                default:      readdata_d = 16'(to_w);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = irq_w;
    assign irq_any  = |irq_w;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Scoreboard bench for avalon_multi_timer: stimulus pushes expected read data and
// interrupt/output probes into queues; a negedge monitor pops and compares them.
module tb_avalon_multi_timer;
    import timer_pkg::*;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int AW     = $clog2(NUM_CH) + 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [15:0]       writedata = '0;
    logic [15:0]       readdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    always #5 clk = ~clk;

    avalon_multi_timer #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (24999999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    typedef struct {
        logic [15:0] exp;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [19:0] exp;
        logic [19:0] mask;
        string       name;
    } pr_exp_t;

    rd_exp_t rd_q[$];
    pr_exp_t pr_q[$];
    rd_exp_t rd_item;
    pr_exp_t pr_item;
    logic [19:0] obs;
    int checks = 0;
    int errors = 0;
    logic rd_vld = 1'b0;
    logic irq_probe = 1'b0;

    always @(posedge clk) rd_vld <= chipselect && write_n;

    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: readdata=%h, no read was expected", readdata);
            end else begin
                rd_item = rd_q.pop_front();
                if (readdata !== rd_item.exp) begin
                    errors++;
                    $display("FAIL %s: readdata=%h expected %h", rd_item.name, readdata, rd_item.exp);
                end
            end
        end
        if (irq_probe) begin
            checks++;
            obs = {readdata, irq_any, irq};
            if (pr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_probe: outputs=%h, no probe was expected", obs);
            end else begin
                pr_item = pr_q.pop_front();
                if ((obs & pr_item.mask) !== pr_item.exp) begin
                    errors++;
                    $display("FAIL %s: {readdata,irq_any,irq}=%h expected %h (mask %h)",
                             pr_item.name, obs & pr_item.mask, pr_item.exp, pr_item.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, bench did not reach its end", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [2:0] r, input logic [15:0] d);
        address    = {ch, r};
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [2:0] r, input logic [15:0] e, input string nm);
        address    = {ch, r};
        chipselect = 1'b1;
        write_n    = 1'b1;
        rd_q.push_back('{e, nm});
        cyc(1);
        chipselect = 1'b0;
    endtask

    task automatic probe(input logic [19:0] e, input logic [19:0] m, input string nm);
        pr_q.push_back('{e, m, nm});
        irq_probe = 1'b1;
        cyc(1);
        irq_probe = 1'b0;
    endtask

    // Checks {irq_any, irq[2:0]} during the current cycle.
    task automatic pirq(input logic [3:0] e, input string nm);
        probe({16'h0000, e}, 20'h0000F, nm);
    endtask

    initial begin
        // Reset state
        cyc(2);
        rd(2'd0, REG_PERIODL, 16'h0000, "readdata_during_reset");
        reset_n = 1'b1;
        pirq(4'b0000, "irq_after_reset");
        rd(2'd0, REG_PERIODL, 16'h783F, "ch0_periodl_reset");
        rd(2'd0, REG_PERIODH, 16'h017D, "ch0_periodh_reset");
        rd(2'd0, REG_STATUS,  16'h0000, "ch0_status_reset");

        // ch1: period 4, continuous, ITO; START lands with the PERIODH reload
        wr(2'd1, REG_PERIODL, 16'd4);
        wr(2'd1, REG_PERIODH, 16'd0);
        wr(2'd1, REG_CONTROL, 16'h0007);
        cyc(4);
        pirq(4'b0000, "ch1_cnt_zero_to_not_yet");
        pirq(4'b1010, "ch1_first_timeout_irq");
        rd(2'd1, REG_STATUS,  16'h0003, "ch1_status_run_to");
        rd(2'd0, REG_PENDING, 16'h0002, "pending_ch0_slot");
        wr(2'd1, REG_STATUS,  16'h0000);
        pirq(4'b0000, "ch1_irq_cleared");
        pirq(4'b1010, "ch1_second_timeout_5_later");
        rd(2'd2, REG_PENDING, 16'h0002, "pending_ch2_slot");
        rd(2'd3, REG_PERIODL, 16'h0000, "absent_channel_reads_zero");
        wr(2'd1, REG_CONTROL, 16'h0008);
        wr(2'd1, REG_STATUS,  16'h0000);

        // ch0: period 3, prescale 2, one-shot, ITO
        wr(2'd0, REG_PERIODL,  16'd3);
        wr(2'd0, REG_PERIODH,  16'd0);
        wr(2'd0, REG_PRESCALE, 16'd2);
        wr(2'd0, REG_CONTROL,  16'h0005);
        cyc(3);
        wr(2'd0, REG_SNAPL, 16'h0000);
        rd(2'd0, REG_SNAPL, 16'd2, "ch0_presc_snap_a");
        wr(2'd0, REG_SNAPH, 16'h0000);
        rd(2'd0, REG_SNAPL, 16'd2, "ch0_presc_snap_b_same");
        wr(2'd0, REG_SNAPL, 16'h0000);
        rd(2'd0, REG_SNAPL, 16'd1, "ch0_presc_snap_c_dec");
        pirq(4'b0000, "ch0_oneshot_to_not_yet");
        pirq(4'b1001, "ch0_oneshot_timeout");
        rd(2'd0, REG_STATUS, 16'h0003, "ch0_oneshot_still_run");
        rd(2'd0, REG_STATUS, 16'h0001, "ch0_oneshot_run_cleared");
        rd(2'd0, REG_SNAPH,  16'h0000, "ch0_snaph_small");
        wr(2'd0, REG_STATUS,  16'h0000);
        wr(2'd0, REG_CONTROL, 16'h0000);

        // ch0: period write while running forces reload and stop
        wr(2'd0, REG_PRESCALE, 16'd0);
        wr(2'd0, REG_PERIODL,  16'd10);
        wr(2'd0, REG_CONTROL,  16'h0006);
        cyc(1);
        wr(2'd0, REG_PERIODL,  16'd7);
        rd(2'd0, REG_STATUS,  16'h0002, "reload_run_still_high");
        rd(2'd0, REG_STATUS,  16'h0000, "reload_run_cleared");
        wr(2'd0, REG_SNAPL,   16'h0000);
        rd(2'd0, REG_SNAPL,   16'd7, "reload_cnt_is_period");
        wr(2'd0, REG_CONTROL, 16'h000C);
        rd(2'd0, REG_STATUS,  16'h0002, "start_beats_stop");
        rd(2'd0, REG_CONTROL, 16'h000C, "control_bits_stored");
        wr(2'd0, REG_CONTROL, 16'h0008);

        // ch0: status clear coincident with a timeout event wins
        wr(2'd0, REG_PERIODL, 16'd2);
        wr(2'd0, REG_CONTROL, 16'h0007);
        cyc(2);
        wr(2'd0, REG_STATUS, 16'h0000);
        pirq(4'b0000, "clear_beats_timeout");
        rd(2'd0, REG_STATUS, 16'h0002, "clear_beats_timeout_status");
        pirq(4'b0000, "ch0_next_to_not_yet");
        pirq(4'b1001, "ch0_next_timeout");
        wr(2'd0, REG_STATUS, 16'h0000);
        pirq(4'b0000, "irq_drops_after_clear");
        wr(2'd0, REG_CONTROL, 16'h0009);

        // ch0: snapshot of a wide count, then asynchronous reset mid-count
        wr(2'd0, REG_PERIODL, 16'h2345);
        wr(2'd0, REG_PERIODH, 16'h0001);
        wr(2'd0, REG_CONTROL, 16'h0007);
        wr(2'd0, REG_SNAPL,   16'h0000);
        rd(2'd0, REG_SNAPL,   16'h2345, "snap_low_pre_edge");
        rd(2'd0, REG_SNAPH,   16'h0001, "snap_high_pre_edge");
        rd(2'd0, REG_PERIODH, 16'h0001, "periodh_written");
        probe({16'h0001, 4'b1001}, 20'hFFFFF, "outputs_before_reset");
        reset_n = 1'b0;
        probe(20'h00000, 20'hFFFFF, "outputs_zero_in_reset");
        reset_n = 1'b1;
        rd(2'd0, REG_PERIODL, 16'h783F, "periodl_after_reset");
        rd(2'd0, REG_SNAPL,   16'h0000, "snapl_after_reset");
        rd(2'd0, REG_CONTROL, 16'h0000, "control_after_reset");
        rd(2'd0, REG_STATUS,  16'h0000, "status_after_reset");

        cyc(3);
        checks++;
        if (rd_q.size() != 0 || pr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d reads and %0d probes left, expected 0 and 0",
                     rd_q.size(), pr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
